// File: rtl/in_port_fifo.sv
// Input-side FIFO peripheral for the SAP-3 bus: a producer pushes bytes over valid/ready, IN pops them.
// Optional sticky overflow flag (status bit2) is built when IN_PORT_OVF_EN is defined.
module in_port_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ext_data,
    input  logic             ext_valid,
    output logic             ext_ready,
    input  logic             oe,
    input  logic             pop,
    input  logic             stat_oe,
    output logic [WIDTH-1:0] out,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             do_push;
    logic             do_pop;
    logic [7:0]       status_byte;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign ext_ready = !full;

    // Gating on full/empty gives the boundary rules: no bypass when empty, no push when full.
    assign do_push = ext_valid && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= ext_data;
        end
    end

`ifdef IN_PORT_OVF_EN
    // A fresh overflow outranks the clear caused by a status read in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ext_valid && full) begin
            ovf <= 1'b1;
        end else if (stat_oe) begin
            ovf <= 1'b0;
        end
    end
`else
    assign ovf = 1'b0;
`endif

    assign status_byte = {4'(count), 1'b0, ovf, full, empty};

    always_comb begin
        out = '0;
        if (stat_oe) begin
            out = status_byte;
        end else if (oe && !empty) begin
            out = mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_in_port_fifo.sv
// Self-checking bench for in_port_fifo: directed steps then random traffic against a queue-based model.
// Build with IN_PORT_OVF_EN defined to exercise the overflow flag expectations.
module tb_in_port_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ext_data;
    logic       ext_valid;
    logic       ext_ready;
    logic       oe;
    logic       pop;
    logic       stat_oe;
    logic [7:0] out;
    logic       empty;
    logic       full;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    logic       ovf_m;

    in_port_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_data  (ext_data),
        .ext_valid (ext_valid),
        .ext_ready (ext_ready),
        .oe        (oe),
        .pop       (pop),
        .stat_oe   (stat_oe),
        .out       (out),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_status();
        return {4'(q.size()), 1'b0, ovf_m, (q.size() == DEPTH), (q.size() == 0)};
    endfunction

    function automatic logic [7:0] model_out();
        if (stat_oe) return model_status();
        if (oe && q.size() > 0) return q[0];
        return 8'h00;
    endfunction

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".out"},   out,                 model_out());
        checkVal({tag, ".empty"}, {7'b0, empty},       {7'b0, q.size() == 0});
        checkVal({tag, ".full"},  {7'b0, full},        {7'b0, q.size() == DEPTH});
        checkVal({tag, ".ready"}, {7'b0, ext_ready},   {7'b0, q.size() != DEPTH});
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d,
                                 input logic o, input logic p, input logic s);
        rst       = r;
        ext_valid = v;
        ext_data  = d;
        oe        = o;
        pop       = p;
        stat_oe   = s;
        #1;
    endtask

    // Model update uses inputs as they stood before the edge.
    task automatic clockEdge();
        int         n;
        logic       pu;
        logic       po;
        logic [7:0] d;
        n  = q.size();
        pu = ext_valid && (n < DEPTH);
        po = pop && (n > 0);
        d  = ext_data;
        @(posedge clk);
        if (rst) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            if (po) void'(q.pop_front());
            if (pu) q.push_back(d);
`ifdef IN_PORT_OVF_EN
            if (ext_valid && n == DEPTH) ovf_m = 1'b1;
            else if (stat_oe) ovf_m = 1'b0;
`endif
        end
        #1;
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] d,
                        input logic o, input logic p, input logic s);
        applyStimulus(1'b0, v, d, o, p, s);
        checkOutput(tag);
        clockEdge();
    endtask

    initial begin
        logic [7:0] fill_bytes [4];
        logic [7:0] ovf_status;
        fill_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        ovf_m = 1'b0;
`ifdef IN_PORT_OVF_EN
        ovf_status = 8'h46;
`else
        ovf_status = 8'h42;
`endif

        // Reset then idle
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        clockEdge();
        clockEdge();
        step("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkVal("idle_out", out, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkVal("idle_status", out, 8'h01);
        clockEdge();

        // Fill, status, overflow attempt, drain
        for (int i = 0; i < 4; i++) step("fill", 1'b1, fill_bytes[i], 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkVal("full_status", out, 8'h42);
        checkVal("full_ready", {7'b0, ext_ready}, 8'h00);
        clockEdge();
        step("push_ee", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkVal("ovf_status", out, ovf_status);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkVal("ovf_cleared", out, 8'h42);
        clockEdge();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
            checkVal("drain_byte", out, fill_bytes[i]);
            checkOutput("drain");
            clockEdge();
        end
        checkVal("drained_empty", {7'b0, empty}, 8'h01);

        // Wrap-around: push 3, pop 2, push 3
        for (int i = 0; i < 3; i++) step("wrap_push1", 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("wrap_push2", 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkVal("wrap_status", out, 8'h42);
        clockEdge();
        for (int i = 0; i < 4; i++) step("wrap_read", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Simultaneous push+pop at count 2, then push+pop on empty
        step("sim_pre", 1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        step("sim_pre", 1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("sim_pp", 1'b1, 8'h70 + 8'(i), 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkVal("sim_status", out, 8'h20);
        clockEdge();
        step("sim_drain", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step("sim_drain", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step("empty_pp", 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkVal("empty_pp_head", out, 8'h55);
        clockEdge();
        step("empty_pp_pop", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Pop while empty, then push 0x12
        for (int i = 0; i < 3; i++) step("pop_empty", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step("push_12", 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkVal("read_12", out, 8'h12);
        clockEdge();

        // Reset with count 3 and a push offered in the reset cycle
        for (int i = 0; i < 3; i++) step("rst_fill", 1'b1, 8'h90 + 8'(i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkVal("post_rst_status", out, 8'h01);
        checkOutput("post_rst");
        clockEdge();

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
                          8'($urandom), ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            checkOutput("random");
            clockEdge();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
